mem_stage_lsu: RTL and testbench

//  CPU-side master for the data-memory port. Sits in the M pipeline stage.
//  Per instruction it drives m_data_addr/wdata/byteen and m_inst_addr, aligns and

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_align.sv | 46 ++++
 rtl/mem_stage_lsu.sv | 88 ++++++++
 tb/tb_mem_stage_lsu.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store op encoding, exception codes and op-class helpers
package lsu_pkg;

   typedef enum logic [3:0] {
      NONE = 4'd0,
      LW   = 4'd1,
      LH   = 4'd2,
      LHU  = 4'd3,
      LB   = 4'd4,
      LBU  = 4'd5,
      SW   = 4'd6,
      SH   = 4'd7,
      SB   = 4'd8
   } lsu_op_t;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   function automatic logic is_load(input lsu_op_t op);
      return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
   endfunction

   function automatic logic is_store(input lsu_op_t op);
      return (op == SW) || (op == SH) || (op == SB);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store strobe/replication, load extract and misalign detect
module lsu_align
   import lsu_pkg::*;
(
   input  lsu_op_t     op,
   input  logic [1:0]  addr,
   input  logic [31:0] rt,
   input  logic [31:0] rdata,
   output logic [3:0]  byteen,
   output logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic        misalign
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign sel_byte = rdata[{addr, 3'b000} +: 8];
   assign sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      byteen   = 4'b0000;
      wdata    = rt;
      ldata    = rdata;
      misalign = 1'b0;
      case (op)
         LW:  misalign = (addr != 2'b00);
         LH:  begin misalign = addr[0]; ldata = {{16{sel_half[15]}}, sel_half}; end
         LHU: begin misalign = addr[0]; ldata = {16'h0000, sel_half}; end
         LB:  ldata = {{24{sel_byte[7]}}, sel_byte};
         LBU: ldata = {24'h000000, sel_byte};
         SW:  begin misalign = (addr != 2'b00); byteen = 4'b1111; end
         SH:  begin
            misalign = addr[0];
            byteen   = addr[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{rt[15:0]}};
         end
         SB:  begin byteen = 4'b0001 << addr; wdata = {4{rt[7:0]}}; end
         default: ;
      endcase
      // A faulting store must never reach memory, whatever the caller does.
      if (misalign)
         byteen = 4'b0000;
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - M-stage data-memory master with W register, exceptions and retire counter
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int          CNT_W  = 32,
   parameter logic [31:0] RST_PC = 32'h0000_3000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_flush,
   input  logic [31:0]      in_pc,
   input  logic [3:0]       in_op,
   input  logic [31:0]      in_addr,
   input  logic [31:0]      in_rt_data,
   input  logic [31:0]      in_alu_result,
   input  logic [4:0]       in_rd,
   input  logic             in_we,
   output logic [31:0]      m_data_addr,
   output logic [31:0]      m_data_wdata,
   output logic [3:0]       m_data_byteen,
   input  logic [31:0]      m_data_rdata,
   output logic [31:0]      m_inst_addr,
   output logic             w_grf_we,
   output logic [4:0]       w_grf_addr,
   output logic [31:0]      w_grf_wdata,
   output logic [31:0]      w_inst_addr,
   output logic             exc_valid,
   output logic [4:0]       exc_code,
   output logic [31:0]      exc_badvaddr,
   output logic [CNT_W-1:0] retire_count
);

   lsu_op_t     op;
   logic        live;
   logic        fault;
   logic [3:0]  al_byteen;
   logic [31:0] al_wdata;
   logic [31:0] al_ldata;
   logic        al_misalign;

   assign op   = lsu_op_t'(in_op);
   // Reset is folded into live so a held-low reset blocks memory writes combinationally.
   assign live  = in_valid & ~in_flush & reset;
   assign fault = live & al_misalign;

   lsu_align u_align (
      .op       (op),
      .addr     (in_addr[1:0]),
      .rt       (in_rt_data),
      .rdata    (m_data_rdata),
      .byteen   (al_byteen),
      .wdata    (al_wdata),
      .ldata    (al_ldata),
      .misalign (al_misalign)
   );

   assign m_data_addr   = in_addr;
   assign m_data_wdata  = al_wdata;
   assign m_data_byteen = live ? al_byteen : 4'b0000;
   assign m_inst_addr   = in_pc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         w_grf_we     <= 1'b0;
         w_grf_addr   <= 5'd0;
         w_grf_wdata  <= 32'd0;
         w_inst_addr  <= RST_PC;
         exc_valid    <= 1'b0;
         exc_code     <= 5'd0;
         exc_badvaddr <= 32'd0;
         retire_count <= '0;
      end else begin
         w_grf_we    <= live & in_we & ~al_misalign;
         w_grf_addr  <= in_rd;
         w_grf_wdata <= is_load(op) ? al_ldata : in_alu_result;
         w_inst_addr <= in_pc;
         exc_valid   <= fault;
         if (fault) begin
            exc_code     <= is_load(op) ? EXC_ADEL : EXC_ADES;
            exc_badvaddr <= in_addr;
         end
         if (live && !al_misalign)
            retire_count <= retire_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu with a word memory model
module tb_mem_stage_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_flush, in_we;
   logic [31:0] in_pc, in_addr, in_rt_data, in_alu_result;
   logic [3:0]  in_op;
   logic [4:0]  in_rd;
   logic [31:0] m_data_addr, m_data_wdata, m_data_rdata, m_inst_addr;
   logic [3:0]  m_data_byteen;
   logic        w_grf_we, exc_valid;
   logic [4:0]  w_grf_addr, exc_code;
   logic [31:0] w_grf_wdata, w_inst_addr, exc_badvaddr;
   logic [3:0]  retire_count;

   logic [31:0] mem [0:63];
   int n_checks = 0;
   int n_pass   = 0;
   int exp_cnt  = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.CNT_W(4), .RST_PC(32'h0000_3000)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_flush(in_flush),
      .in_pc(in_pc), .in_op(in_op), .in_addr(in_addr), .in_rt_data(in_rt_data),
      .in_alu_result(in_alu_result), .in_rd(in_rd), .in_we(in_we),
      .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
      .m_data_rdata(m_data_rdata), .m_inst_addr(m_inst_addr),
      .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
      .w_inst_addr(w_inst_addr), .exc_valid(exc_valid), .exc_code(exc_code),
      .exc_badvaddr(exc_badvaddr), .retire_count(retire_count)
   );

   assign m_data_rdata = mem[m_data_addr[7:2]];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (m_data_byteen[b])
            mem[m_data_addr[7:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic drive(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] alu, input logic [4:0] rd, input logic we,
                        input logic [31:0] pc, input logic valid, input logic flush);
      in_op = op; in_addr = addr; in_rt_data = rt; in_alu_result = alu;
      in_rd = rd; in_we = we; in_pc = pc; in_valid = valid; in_flush = flush;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      reset = 1'b0;
      drive(SW, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd1, 1'b1, 32'h0000_1000, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("rst_byteen", {28'h0, m_data_byteen}, 32'h0);
         tick();
         check("rst_inst_addr", w_inst_addr, 32'h0000_3000);
         check("rst_retire", {28'h0, retire_count}, 32'h0);
         check("rst_grf_we", {31'h0, w_grf_we}, 32'h0);
         check("rst_exc", {31'h0, exc_valid}, 32'h0);
      end
      check("rst_mem0", mem[0], 32'h0);

      reset = 1'b1;
      drive(SB, 32'h13, 32'hAABB_CCDD, 32'h0, 5'd0, 1'b0, 32'h0000_3000, 1'b1, 1'b0);
      check("sb_byteen", {28'h0, m_data_byteen}, 32'h8);
      check("sb_wdata", m_data_wdata, 32'hDDDD_DDDD);
      tick(); exp_cnt++;
      check("sb_mem", mem[4], 32'hDD00_0000);
      check("sb_retire", {28'h0, retire_count}, exp_cnt[31:0] & 32'hF);

      drive(LB, 32'h13, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_3004, 1'b1, 1'b0);
      check("lb_byteen", {28'h0, m_data_byteen}, 32'h0);
      tick(); exp_cnt++;
      check("lb_we", {31'h0, w_grf_we}, 32'h1);
      check("lb_rd", {27'h0, w_grf_addr}, 32'd3);
      check("lb_data", w_grf_wdata, 32'hFFFF_FFDD);

      drive(LBU, 32'h13, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_3008, 1'b1, 1'b0);
      tick(); exp_cnt++;
      check("lbu_data", w_grf_wdata, 32'h0000_00DD);

      drive(SH, 32'h22, 32'h0000_8001, 32'h0, 5'd0, 1'b0, 32'h0000_300C, 1'b1, 1'b0);
      check("sh_byteen", {28'h0, m_data_byteen}, 32'hC);
      check("sh_wdata", m_data_wdata, 32'h8001_8001);
      tick(); exp_cnt++;
      drive(LH, 32'h22, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_3010, 1'b1, 1'b0);
      tick(); exp_cnt++;
      check("lh_data", w_grf_wdata, 32'hFFFF_8001);
      drive(LHU, 32'h22, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_3014, 1'b1, 1'b0);
      tick(); exp_cnt++;
      check("lhu_data", w_grf_wdata, 32'h0000_8001);
      check("retire_6", {28'h0, retire_count}, exp_cnt[31:0] & 32'hF);

      drive(LW, 32'h6, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0000_3018, 1'b1, 1'b0);
      tick();
      check("adel_we", {31'h0, w_grf_we}, 32'h0);
      check("adel_valid", {31'h0, exc_valid}, 32'h1);
      check("adel_code", {27'h0, exc_code}, 32'd4);
      check("adel_bad", exc_badvaddr, 32'h6);
      check("adel_retire", {28'h0, retire_count}, exp_cnt[31:0] & 32'hF);
      drive(NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0000_301C, 1'b0, 1'b0);
      tick();
      check("exc_pulse_end", {31'h0, exc_valid}, 32'h0);

      drive(SW, 32'h5, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 32'h0000_3020, 1'b1, 1'b0);
      check("ades_byteen", {28'h0, m_data_byteen}, 32'h0);
      tick();
      check("ades_valid", {31'h0, exc_valid}, 32'h1);
      check("ades_code", {27'h0, exc_code}, 32'd5);
      check("ades_bad", exc_badvaddr, 32'h5);
      check("ades_mem", mem[1], 32'h0);

      drive(SW, 32'h4, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 32'h0000_3024, 1'b1, 1'b1);
      check("flush_byteen", {28'h0, m_data_byteen}, 32'h0);
      tick();
      check("flush_exc", {31'h0, exc_valid}, 32'h0);
      check("flush_retire", {28'h0, retire_count}, exp_cnt[31:0] & 32'hF);
      check("flush_mem", mem[1], 32'h0);
      drive(SW, 32'h5, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 32'h0000_3028, 1'b1, 1'b1);
      tick();
      check("flush_misalign_exc", {31'h0, exc_valid}, 32'h0);

      drive(NONE, 32'h0, 32'h0, 32'h0000_1234, 5'd8, 1'b1, 32'h0000_3100, 1'b1, 1'b0);
      tick(); exp_cnt++;
      check("addu_we", {31'h0, w_grf_we}, 32'h1);
      check("addu_rd", {27'h0, w_grf_addr}, 32'd8);
      check("addu_data", w_grf_wdata, 32'h0000_1234);
      check("addu_pc", w_inst_addr, 32'h0000_3100);
      drive(LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 5'd9, 1'b1, 32'h0000_3104, 1'b1, 1'b0);
      tick(); exp_cnt++;
      check("lw_we", {31'h0, w_grf_we}, 32'h1);
      check("lw_rd", {27'h0, w_grf_addr}, 32'd9);
      check("lw_data", w_grf_wdata, 32'hDD00_0000);
      check("lw_pc", w_inst_addr, 32'h0000_3104);

      reset = 1'b0;
      drive(SW, 32'h8, 32'hCAFE_F00D, 32'h0, 5'd7, 1'b1, 32'h0000_3108, 1'b1, 1'b0);
      check("midrst_byteen", {28'h0, m_data_byteen}, 32'h0);
      tick(); exp_cnt = 0;
      check("midrst_we", {31'h0, w_grf_we}, 32'h0);
      check("midrst_mem", mem[2], 32'h0);
      check("midrst_retire", {28'h0, retire_count}, 32'h0);
      check("midrst_pc", w_inst_addr, 32'h0000_3000);
      reset = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0000_3200 + 32'(4 * i), 1'b1, 1'b0);
         tick(); exp_cnt++;
      end
      check("cnt_allones", {28'h0, retire_count}, 32'hF);
      drive(NONE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0000_3300, 1'b1, 1'b0);
      tick(); exp_cnt++;
      check("cnt_wrap", {28'h0, retire_count}, exp_cnt[31:0] & 32'hF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
